// File: rtl/rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb_pkg
// Shared types and constants for the 8-way round-robin arbiter (rr_arb_8_n)
// and its circular priority picker (rr_pick_8).
//   state_t      : arbiter FSM states (IDLE, GRANT)
//   NREQ         : number of requesters (fixed at 8)
//   IDX_W        : grant index width, $clog2(NREQ)
//   HOLD_MAX_DEF : default maximum grant tenure when RR_ARB_TIMEOUT_EN is set
// ----------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int NREQ         = 8;
    localparam int IDX_W        = 3;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : rr_arb_pkg

// File: rtl/rr_pick_8.sv
// ----------------------------------------------------------------------------
// rr_pick_8
// Purely combinational circular priority picker. Finds the first set bit of
// req searching upward from ptr+1 and wrapping modulo 8, so the requester at
// ptr itself has the lowest priority.
// Ports:
//   req [7:0] in  : request vector
//   ptr [2:0] in  : index of the last owner
//   any       out : at least one request is set
//   idx [2:0] out : chosen requester (meaningless when any=0)
// ----------------------------------------------------------------------------
module rr_pick_8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       any,
    output logic [2:0] idx
);
    import rr_arb_pkg::*;

    // rot[k] is the request of the requester k+1 positions after ptr, so the
    // lowest set bit of rot is the highest-priority request.
    logic [7:0] rot;
    logic [2:0] off;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign rot[gi] = req[3'(ptr + 3'(gi + 1))];
    end

    always_comb begin
        off = 3'd0;
        // Descending scan: the last hit written is the lowest set bit.
        for (int k = 7; k >= 0; k--) begin
            if (rot[k]) begin
                off = 3'(k);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + 3'd1 + off;

endmodule : rr_pick_8

// File: rtl/rr_arb_8_n.sv
// ----------------------------------------------------------------------------
// rr_arb_8_n
// Round-robin arbiter sharing one resource among 8 requesters. A grant is
// held until the owner pulses done or drops its request; every release is
// followed by exactly one idle turnaround cycle before the next grant.
// Optional feature (macro RR_ARB_TIMEOUT_EN): bounds grant tenure to HOLD_MAX
// cycles with a forced release flagged by a one-cycle gnt_timeout pulse.
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : asynchronous active-high reset
//   req [7:0]    in  : level requests, held until granted and released
//   done         in  : release pulse from the current owner
//   gnt_valid    out : a grant is active
//   gnt_idx[2:0] out : current owner; holds last owner while idle
//   gnt_n [7:0]  out : active-low one-hot grant, 8'hFF when idle
//   gnt_timeout  out : one-cycle pulse on forced release (0 without macro)
// All outputs come straight from registers or from a decode of registers.
// ----------------------------------------------------------------------------
module rr_arb_8_n #(
    parameter int NREQ     = rr_arb_pkg::NREQ,
    parameter int IDX_W    = rr_arb_pkg::IDX_W,
    parameter int HOLD_MAX = rr_arb_pkg::HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [NREQ-1:0]  gnt_n,
    output logic             gnt_timeout
);
    import rr_arb_pkg::*;

    if (NREQ != 8) begin : g_bad_nreq
        $fatal(1, "rr_arb_8_n: NREQ must be 8");
    end
    if (IDX_W != $clog2(NREQ)) begin : g_bad_idx_w
        $fatal(1, "rr_arb_8_n: IDX_W must be clog2(NREQ)");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $fatal(1, "rr_arb_8_n: HOLD_MAX must be in 2..255");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             rel_norm;
    logic             rel_force;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_pick_8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        rel_norm  = 1'b0;
        rel_force = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        // Cleared while idle so it reads 0 on the first granted cycle.
        cnt_d     = (state_q == GRANT) ? cnt_q + 8'd1 : 8'd0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                rel_norm = done || !req[idx_q];
`ifdef RR_ARB_TIMEOUT_EN
                rel_force = !rel_norm && (cnt_q == 8'(HOLD_MAX - 1));
`endif
                if (rel_norm || rel_force) begin
                    ptr_d   = idx_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef RR_ARB_TIMEOUT_EN
        tmo_d = rel_force;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NREQ - 1);
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    assign gnt_timeout = tmo_q;
`else
    assign gnt_timeout = 1'b0;
`endif

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt_n
        assign gnt_n[gi] = ~(gnt_valid && (idx_q == IDX_W'(gi)));
    end

endmodule : rr_arb_8_n

// File: tb/tb_rr_arb_8_n.sv
module tb_rr_arb_8_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_n;
    logic       gnt_timeout;

    int total = 0;
    int bad   = 0;

    rr_arb_8_n dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt_valid   (gnt_valid),
        .gnt_idx     (gnt_idx),
        .gnt_n       (gnt_n),
        .gnt_timeout (gnt_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        req  = 8'h00;
        done = 1'b0;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        step(); step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
        total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx); end
        total++; if (gnt_n !== 8'hFF) begin bad++; $display("FAIL reset_gnt_n got=%h exp=ff", gnt_n); end
        total++; if (gnt_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", gnt_timeout); end
        rst = 1'b0;
        $display("test_reset: checked reset values");
    endtask

    task automatic test_basic();
        do_reset();
        req = 8'h01;
        step();
        total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin bad++; $display("FAIL basic_grant got valid=%b idx=%0d exp valid=1 idx=0", gnt_valid, gnt_idx); end
        total++; if (gnt_n !== 8'hFE) begin bad++; $display("FAIL basic_gnt_n got=%h exp=fe", gnt_n); end
        done = 1'b1;
        step();
        done = 1'b0;
        total++; if (gnt_n !== 8'hFF || gnt_valid !== 1'b0) begin bad++; $display("FAIL basic_release got gnt_n=%h valid=%b exp ff/0", gnt_n, gnt_valid); end
        req = 8'h00;
        step();
        $display("test_basic: single grant and release");
    endtask

    task automatic test_rotation();
        int seen[8];
        for (int i = 0; i < 8; i++) seen[i] = 0;
        do_reset();
        req = 8'hFF;
        step();
        for (int g = 0; g < 9; g++) begin
            total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'(g % 8)) begin bad++; $display("FAIL rot_grant%0d got valid=%b idx=%0d exp valid=1 idx=%0d", g, gnt_valid, gnt_idx, g % 8); end
            total++; if (gnt_n !== ~(8'h01 << (g % 8))) begin bad++; $display("FAIL rot_gnt_n%0d got=%h exp=%h", g, gnt_n, ~(8'h01 << (g % 8))); end
            if (g < 8) seen[gnt_idx]++;
            $display("rotation grant %0d idx=%0d", g, gnt_idx);
            done = 1'b1;
            if (g == 8) req = 8'h00;
            step();
            done = 1'b0;
            total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL rot_idle%0d got valid=%b exp=0", g, gnt_valid); end
            step();
        end
        for (int i = 0; i < 8; i++) begin
            total++; if (seen[i] !== 1) begin bad++; $display("FAIL rot_count idx=%0d got=%0d exp=1", i, seen[i]); end
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 8'h28;
        step();
        total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin bad++; $display("FAIL wd_grant got valid=%b idx=%0d exp 1/3", gnt_valid, gnt_idx); end
        req = 8'h20;
        step();
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL wd_release got valid=%b exp=0", gnt_valid); end
        step();
        total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin bad++; $display("FAIL wd_next got valid=%b idx=%0d exp 1/5", gnt_valid, gnt_idx); end
        req = 8'h00;
        step();
        $display("test_withdraw: owner 3 withdrew, next owner %0d", 5);
    endtask

    task automatic test_same_cycle();
        do_reset();
        req = 8'h01;
        step();
        total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin bad++; $display("FAIL sc_grant got valid=%b idx=%0d exp 1/0", gnt_valid, gnt_idx); end
        done = 1'b1; req = 8'h00;
        step();
        done = 1'b0;
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL sc_release got valid=%b exp=0", gnt_valid); end
        done = 1'b1;
        step();
        done = 1'b0;
        total++; if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_n !== 8'hFF) begin bad++; $display("FAIL sc_idle_done got valid=%b idx=%0d gnt_n=%h exp 0/0/ff", gnt_valid, gnt_idx, gnt_n); end
        req = 8'h03;
        step();
        total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd1) begin bad++; $display("FAIL sc_next got valid=%b idx=%0d exp 1/1", gnt_valid, gnt_idx); end
        req = 8'h00;
        step();
        $display("test_same_cycle: done+drop released once");
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h40;
        step();
        total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6) begin bad++; $display("FAIL rm_grant got valid=%b idx=%0d exp 1/6", gnt_valid, gnt_idx); end
        rst = 1'b1;
        #1;
        total++; if (gnt_valid !== 1'b0 || gnt_n !== 8'hFF || gnt_idx !== 3'd0) begin bad++; $display("FAIL rm_async got valid=%b gnt_n=%h idx=%0d exp 0/ff/0", gnt_valid, gnt_n, gnt_idx); end
        req = 8'h41;
        step();
        rst = 1'b0;
        step();
        total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin bad++; $display("FAIL rm_regrant got valid=%b idx=%0d exp 1/0", gnt_valid, gnt_idx); end
        req = 8'h00;
        step();
        $display("test_reset_mid: async reset during grant");
    endtask

    task automatic test_hold();
        int hi = 0;
        int tmo_seen = 0;
        do_reset();
        req = 8'h04;
        step();
`ifdef RR_ARB_TIMEOUT_EN
        while (gnt_valid === 1'b1 && hi < 40) begin
            if (gnt_timeout !== 1'b0) tmo_seen++;
            hi++;
            step();
        end
        total++; if (hi !== 16) begin bad++; $display("FAIL tmo_tenure got=%0d exp=16", hi); end
        total++; if (gnt_timeout !== 1'b1 || tmo_seen !== 0) begin bad++; $display("FAIL tmo_pulse got=%b early=%0d exp 1/0", gnt_timeout, tmo_seen); end
        step();
        total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || gnt_timeout !== 1'b0) begin bad++; $display("FAIL tmo_regrant got valid=%b idx=%0d tmo=%b exp 1/2/0", gnt_valid, gnt_idx, gnt_timeout); end
        $display("test_hold: timeout tenure=%0d", hi);
`else
        while (gnt_valid === 1'b1 && hi < 20) begin
            if (gnt_timeout !== 1'b0) tmo_seen++;
            hi++;
            step();
        end
        total++; if (hi !== 20) begin bad++; $display("FAIL hold_tenure got=%0d exp=20", hi); end
        total++; if (tmo_seen !== 0) begin bad++; $display("FAIL hold_timeout got=%0d exp=0", tmo_seen); end
        $display("test_hold: grant held %0d cycles", hi);
`endif
        req = 8'h00;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_withdraw();
        test_same_cycle();
        test_reset_mid();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arb_8_n

// File: doc/rr_arb_8_n.md
Name: rr_arb_8_n

Overview:
- Round-robin arbiter sharing one resource among 8 requesters in the hw_pq datapath (e.g. the single queue-storage write port).
- Grant is held until the owner releases it.
- Grant is presented two ways:
  - encoded index plus valid;
  - active-low one-hot bus `gnt_n`, for requesters that use active-low enables.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 in this revision, any other value is a fatal elaboration error.
- IDX_W, 3, width of the grant index, $clog2(NREQ).
- HOLD_MAX, 16, maximum grant tenure in cycles; used only when RR_ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  8  request per requester; level, held until granted and released.
- done  in  1  release pulse from the current owner.
- gnt_valid  out  1  a grant is active.
- gnt_idx  out  3  index of the current owner; holds the last owner when gnt_valid=0.
- gnt_n  out  8  active-low one-hot grant; 8'hFF when gnt_valid=0.
- gnt_timeout  out  1  one-cycle pulse on forced release; tied to 0 without RR_ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert) values:
  - state=IDLE, ptr=3'd7, gnt_idx=0, gnt_valid=0, gnt_n=8'hFF, gnt_timeout=0, hold counter=0.
  - ptr=7 means requester 0 has top priority after reset.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req != 0, pick the first set bit searching circularly from ptr+1 (mod 8).
  - Register the pick into gnt_idx, set gnt_valid, go to GRANT.
  - Grant is visible on the cycle after req is sampled (latency 1).
  - If req == 0, stay in IDLE; `done` is ignored.
- GRANT releases when either of these is sampled:
  - `done`=1, or
  - `req[gnt_idx]`=0 (owner withdrew).
- On release:
  - ptr <= gnt_idx, gnt_valid <= 0, go to IDLE.
  - There is always exactly one idle turnaround cycle between consecutive grants.
- `done` and owner req drop in the same cycle count as a single release.
- While in GRANT, requests from non-owners are ignored; they stay pending.
- `gnt_n` is decoded combinationally from the registered gnt_idx/gnt_valid: `gnt_n = gnt_valid ? ~(8'b1 << gnt_idx) : 8'hFF`. There is no combinational path from any input to any output.
- Fairness: a continuously asserted request is granted within 7 foreign tenures.
- Reset asserted mid-grant: outputs return to reset values immediately (async); the pending request is re-arbitrated from ptr=7 after reset release.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When counter == HOLD_MAX-1 and no normal release occurs, force a release (same ptr update as a normal release) and pulse gnt_timeout for 1 cycle, aligned with gnt_valid falling.
  - Tenure is therefore at most HOLD_MAX cycles.
- Not defined: no counter; gnt_timeout is constant 0; grant is held indefinitely.

Decomposition:
- Package rr_arb_pkg contains:
  - `state_t` enum {IDLE, GRANT};
  - localparams NREQ=8 and IDX_W=3;
  - a default HOLD_MAX constant.
- Sub-module rr_pick_8: purely combinational circular priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
- The top module holds the FSM, pointer, counter and output decode.

Test Plan:
- Reset then req=8'h01 -> next cycle gnt_valid=1, gnt_idx=0, gnt_n=8'hFE; pulse done -> next cycle gnt_n=8'hFF.
- req=8'hFF held, done pulsed every grant -> grant order 0,1,2,...,7,0 with one idle cycle between grants; each index appears exactly once per 8 grants.
- Owner 3 granted with req=8'h28; drop req[3] without done -> release; next grant is idx 5; ptr=3.
- done and req[owner] drop in the same cycle -> exactly one release and one idle cycle; `done` pulsed in IDLE with req=0 -> no state change.
- rst asserted mid-grant (idx 6) -> gnt_n=8'hFF and gnt_valid=0 immediately; after release with req=8'h41 -> idx 0 granted.
- RR_ARB_TIMEOUT_EN, HOLD_MAX=16, req=8'h04 held, no done -> gnt_valid high exactly 16 cycles, gnt_timeout pulses once, re-grant of idx 2 follows after 1 idle cycle.
